// File: rtl/piso_readout_ctrl.sv
// piso_readout_ctrl
//
// Sequences one readout frame of the test chip's PISO error-count chains.
// A frame parallel-loads the chip (one shift_clk pulse with load high),
// then issues NUM_BITS shift pulses with load low, LSB first, then a tail
// half-period before load returns high. shift_clk is derived from clk by
// holding each level for CLK_DIV system cycles. Every output is a flop.
//
// Parameters:
//   CLK_DIV     system-clock cycles per shift_clk half-period (1..255)
//   NUM_BITS    shift pulses per frame (1..63)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle frame request, honoured only while idle
//   abort        terminates a frame in progress
//   load         1 = parallel load/hold, 0 = shift
//   shift_clk    divided shift clock to chip and capture stage
//   busy         frame in progress
//   done         one-cycle pulse on normal frame completion
//   aborted      one-cycle pulse when a frame is terminated by abort
//   bit_idx      index of the bit presented at the next shift rising edge
//   frame_count  completed frames, wrapping at 16 bits
module piso_readout_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int NUM_BITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        load,
  output logic        shift_clk,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [5:0]  bit_idx,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_LOW  = 3'd1,
    LD_HIGH = 3'd2,
    LD_HOLD = 3'd3,
    SH_LOW  = 3'd4,
    SH_HIGH = 3'd5,
    TAIL    = 3'd6
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(NUM_BITS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic [7:0]  div_nxt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_nxt;
  logic [15:0] frame_cnt;
  logic [15:0] frame_cnt_nxt;

  logic        div_wrap;
  logic        frame_end;
  logic        abort_evt;

  logic        load_nxt;
  logic        shift_clk_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        aborted_nxt;

  assign div_wrap  = (div_cnt == DIV_LAST);
  // Abort beats a completion landing in the same cycle: no done then.
  assign abort_evt = (state != IDLE) && abort;
  assign frame_end = (state == TAIL) && div_wrap && !abort;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      load      <= 1'b1;
      shift_clk <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      frame_cnt <= frame_cnt_nxt;
      load      <= load_nxt;
      shift_clk <= shift_clk_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      aborted   <= aborted_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      // Abort together with start keeps the block idle.
      if (start && !abort) state_nxt = LD_LOW;
    end else if (abort) begin
      state_nxt = IDLE;
    end else if (div_wrap) begin
      case (state)
        LD_LOW:  state_nxt = LD_HIGH;
        LD_HIGH: state_nxt = LD_HOLD;
        LD_HOLD: state_nxt = SH_LOW;
        SH_LOW:  state_nxt = SH_HIGH;
        SH_HIGH: state_nxt = (bit_cnt == BIT_LAST) ? TAIL : SH_LOW;
        TAIL:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next values of every registered output
  always_comb begin
    // Divider restarts on every state change and sits at zero while idle.
    if ((state_nxt != state) || (state_nxt == IDLE)) div_nxt = '0;
    else                                             div_nxt = div_cnt + 8'd1;

    // bit_cnt only carries a value while shifting; it advances as each
    // shift-high half-period ends so it is stable before the next edge.
    if ((state == SH_HIGH) && (state_nxt == SH_LOW))
      bit_nxt = bit_cnt + 6'd1;
    else if ((state_nxt == SH_LOW) || (state_nxt == SH_HIGH))
      bit_nxt = bit_cnt;
    else
      bit_nxt = '0;

    load_nxt      = !((state_nxt == SH_LOW) || (state_nxt == SH_HIGH) ||
                      (state_nxt == TAIL));
    shift_clk_nxt = (state_nxt == LD_HIGH) || (state_nxt == SH_HIGH);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = frame_end;
    aborted_nxt   = abort_evt;
    frame_cnt_nxt = frame_cnt + 16'(frame_end);
  end

  assign bit_idx     = bit_cnt;
  assign frame_count = frame_cnt;

endmodule

// File: tb/tb_piso_readout_ctrl.sv
// Directed bench for piso_readout_ctrl: one instance at CLK_DIV=4, one at
// CLK_DIV=1, both NUM_BITS=12, with a chip PISO / capture-stage model on the
// CLK_DIV=4 instance.
module tb_piso_readout_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, abort4, start1, abort1;
  logic        load4, shift_clk4, busy4, done4, aborted4;
  logic        load1, shift_clk1, busy1, done1, aborted1;
  logic [5:0]  bit_idx4, bit_idx1;
  logic [15:0] frame_count4, frame_count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_readout_ctrl #(.CLK_DIV(4), .NUM_BITS(12)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .load(load4), .shift_clk(shift_clk4), .busy(busy4), .done(done4),
    .aborted(aborted4), .bit_idx(bit_idx4), .frame_count(frame_count4)
  );

  piso_readout_ctrl #(.CLK_DIV(1), .NUM_BITS(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .load(load1), .shift_clk(shift_clk1), .busy(busy1), .done(done1),
    .aborted(aborted1), .bit_idx(bit_idx1), .frame_count(frame_count1)
  );

  // Chip PISO and capture stage on the CLK_DIV=4 instance.
  localparam logic [11:0] CHIP_DATA = 12'hA5C;
  logic [11:0] chip4 = '0;
  logic [11:0] capt4 = '0;
  int ld_edges4 = 0, sh_edges4 = 0, bit_err4 = 0, frame_sh4 = 0;
  int done_cnt4 = 0, abt_cnt4 = 0;
  int edges1 = 0, hi_cycles1 = 0;

  always @(posedge shift_clk4) begin
    if (load4) begin
      ld_edges4++;
      chip4 = CHIP_DATA;
      frame_sh4 = 0;
    end else begin
      sh_edges4++;
      if (bit_idx4 != 6'(frame_sh4)) bit_err4++;
      frame_sh4++;
      capt4 = {chip4[0], capt4[11:1]};
      chip4 = {1'b0, chip4[11:1]};
    end
  end

  always @(posedge clk) begin
    if (done4 === 1'b1) done_cnt4++;
    if (aborted4 === 1'b1) abt_cnt4++;
    if (shift_clk1 === 1'b1) hi_cycles1++;
  end

  always @(posedge shift_clk1) edges1++;

  task automatic test_reset;
    rst_n = 1'b0; start4 = 0; abort4 = 0; start1 = 0; abort1 = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (load4 !== 1'b1) begin n_fail++; $display("FAIL reset_load: got %0b expected 1", load4); end
    n_checks++; if (shift_clk4 !== 1'b0) begin n_fail++; $display("FAIL reset_shift_clk: got %0b expected 0", shift_clk4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy4); end
    n_checks++; if ({done4, aborted4} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %0b expected 00", {done4, aborted4}); end
    n_checks++; if (bit_idx4 !== 6'd0) begin n_fail++; $display("FAIL reset_bit_idx: got %0d expected 0", bit_idx4); end
    n_checks++; if (frame_count4 !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0h expected 0", frame_count4); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({load4, shift_clk4, busy4} !== 3'b100) begin n_fail++; $display("FAIL idle_outputs: got %0b expected 100", {load4, shift_clk4, busy4}); end
  endtask

  task automatic test_single_frame;
    int l0 = ld_edges4, s0 = sh_edges4, cnt = 0;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %0b expected 1", busy4); end
    while (done4 !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    n_checks++; if (cnt != 112) begin n_fail++; $display("FAIL single_latency: got %0d expected 112", cnt); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %0b expected 0", busy4); end
    n_checks++; if (ld_edges4 - l0 != 1) begin n_fail++; $display("FAIL single_load_edges: got %0d expected 1", ld_edges4 - l0); end
    n_checks++; if (sh_edges4 - s0 != 12) begin n_fail++; $display("FAIL single_shift_edges: got %0d expected 12", sh_edges4 - s0); end
    n_checks++; if (capt4 !== CHIP_DATA) begin n_fail++; $display("FAIL single_capture: got %0h expected %0h", capt4, CHIP_DATA); end
    n_checks++; if (frame_count4 !== 16'd1) begin n_fail++; $display("FAIL single_frame_count: got %0d expected 1", frame_count4); end
    n_checks++; if (bit_err4 != 0) begin n_fail++; $display("FAIL single_bit_idx: got %0d wrong edges expected 0", bit_err4); end
    n_checks++; if (load4 !== 1'b1) begin n_fail++; $display("FAIL single_load_back: got %0b expected 1", load4); end
    @(negedge clk);
    n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %0b expected 0", done4); end
  endtask

  task automatic test_start_ignored;
    int l0 = ld_edges4, s0 = sh_edges4, a0 = abt_cnt4, cnt = 0;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    while (done4 !== 1'b1 && cnt < 2000) begin
      @(negedge clk); cnt++;
      start4 = (cnt == 40);
    end
    start4 = 1'b0;
    n_checks++; if (cnt != 112) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 112", cnt); end
    n_checks++; if (sh_edges4 - s0 != 12 || ld_edges4 - l0 != 1) begin n_fail++; $display("FAIL busy_start_edges: got %0d/%0d expected 1/12", ld_edges4 - l0, sh_edges4 - s0); end
    n_checks++; if (frame_count4 !== 16'd2) begin n_fail++; $display("FAIL busy_start_frame_count: got %0d expected 2", frame_count4); end
    @(negedge clk);
    start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk); start4 = 1'b0; abort4 = 1'b0;
    n_checks++; if ({busy4, aborted4} !== 2'b00) begin n_fail++; $display("FAIL start_abort_idle: got %0b expected 00", {busy4, aborted4}); end
    repeat (20) @(negedge clk);
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %0b expected 0", busy4); end
    n_checks++; if (sh_edges4 - s0 != 12 || ld_edges4 - l0 != 1) begin n_fail++; $display("FAIL start_abort_edges: got %0d/%0d expected 1/12", ld_edges4 - l0, sh_edges4 - s0); end
    n_checks++; if (abt_cnt4 != a0) begin n_fail++; $display("FAIL start_abort_pulse: got %0d expected %0d", abt_cnt4, a0); end
    n_checks++; if (frame_count4 !== 16'd2) begin n_fail++; $display("FAIL start_abort_frame_count: got %0d expected 2", frame_count4); end
  endtask

  task automatic test_abort;
    int s0 = sh_edges4, d0 = done_cnt4, cnt = 0;
    logic [15:0] fc0 = frame_count4;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    while (sh_edges4 - s0 < 5 && cnt < 2000) begin @(negedge clk); cnt++; end
    n_checks++; if (bit_idx4 !== 6'd4) begin n_fail++; $display("FAIL abort_bit_idx_before: got %0d expected 4", bit_idx4); end
    abort4 = 1'b1;
    @(negedge clk); abort4 = 1'b0;
    n_checks++; if (aborted4 !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %0b expected 1", aborted4); end
    n_checks++; if ({load4, shift_clk4, busy4, done4} !== 4'b1000) begin n_fail++; $display("FAIL abort_outputs: got %0b expected 1000", {load4, shift_clk4, busy4, done4}); end
    n_checks++; if (bit_idx4 !== 6'd0) begin n_fail++; $display("FAIL abort_bit_idx: got %0d expected 0", bit_idx4); end
    @(negedge clk);
    n_checks++; if (aborted4 !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_width: got %0b expected 0", aborted4); end
    repeat (150) @(negedge clk);
    n_checks++; if (done_cnt4 != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt4, d0); end
    n_checks++; if (frame_count4 !== fc0) begin n_fail++; $display("FAIL abort_frame_count: got %0d expected %0d", frame_count4, fc0); end
    n_checks++; if (sh_edges4 - s0 != 5) begin n_fail++; $display("FAIL abort_edges: got %0d expected 5", sh_edges4 - s0); end
    s0 = sh_edges4; cnt = 0;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    while (done4 !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    n_checks++; if (cnt != 112) begin n_fail++; $display("FAIL post_abort_latency: got %0d expected 112", cnt); end
    n_checks++; if (sh_edges4 - s0 != 12) begin n_fail++; $display("FAIL post_abort_edges: got %0d expected 12", sh_edges4 - s0); end
    n_checks++; if (capt4 !== CHIP_DATA) begin n_fail++; $display("FAIL post_abort_capture: got %0h expected %0h", capt4, CHIP_DATA); end
    n_checks++; if (frame_count4 !== fc0 + 16'd1) begin n_fail++; $display("FAIL post_abort_frame_count: got %0d expected %0d", frame_count4, fc0 + 16'd1); end
  endtask

  task automatic test_clkdiv1;
    int e0 = edges1, h0 = hi_cycles1, cnt = 0;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    while (done1 !== 1'b1 && cnt < 500) begin @(negedge clk); cnt++; end
    n_checks++; if (cnt != 28) begin n_fail++; $display("FAIL div1_latency1: got %0d expected 28", cnt); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL div1_busy_gap: got %0b expected 0", busy1); end
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL div1_back_to_back: got %0b expected 1", busy1); end
    cnt = 0;
    while (done1 !== 1'b1 && cnt < 500) begin @(negedge clk); cnt++; end
    n_checks++; if (cnt != 28) begin n_fail++; $display("FAIL div1_latency2: got %0d expected 28", cnt); end
    n_checks++; if (edges1 - e0 != 26) begin n_fail++; $display("FAIL div1_edges: got %0d expected 26", edges1 - e0); end
    n_checks++; if (hi_cycles1 - h0 != 26) begin n_fail++; $display("FAIL div1_high_cycles: got %0d expected 26", hi_cycles1 - h0); end
    n_checks++; if (frame_count1 !== 16'd2) begin n_fail++; $display("FAIL div1_frame_count: got %0d expected 2", frame_count1); end
  endtask

  task automatic test_reset_midframe;
    int cnt = 0;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    while (!(load4 === 1'b0 && shift_clk4 === 1'b1) && cnt < 2000) begin @(negedge clk); cnt++; end
    n_checks++; if (frame_count4 === 16'd0) begin n_fail++; $display("FAIL midframe_precount: got %0d expected nonzero", frame_count4); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({load4, shift_clk4, busy4} !== 3'b100) begin n_fail++; $display("FAIL midframe_reset_outputs: got %0b expected 100", {load4, shift_clk4, busy4}); end
    n_checks++; if (frame_count4 !== 16'd0) begin n_fail++; $display("FAIL midframe_reset_count: got %0d expected 0", frame_count4); end
    n_checks++; if (bit_idx4 !== 6'd0) begin n_fail++; $display("FAIL midframe_reset_bit_idx: got %0d expected 0", bit_idx4); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int cnt = 0;
    force dut4.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut4.frame_cnt;
    @(negedge clk);
    n_checks++; if (frame_count4 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset: got %0h expected ffff", frame_count4); end
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    while (done4 !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    n_checks++; if (cnt != 112) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 112", cnt); end
    n_checks++; if (frame_count4 !== 16'h0000) begin n_fail++; $display("FAIL wrap_frame_count: got %0h expected 0", frame_count4); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_start_ignored();
    test_abort();
    test_clkdiv1();
    test_reset_midframe();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
